// File: rtl/key_pio_pkg.sv
// Shared definitions for the key PIO irq master: FSM states and PIO register map.
package key_pio_pkg;

  typedef enum logic [2:0] {
    S_WMASK,
    S_IDLE,
    S_POLL,
    S_RD,
    S_RDV
  } state_t;

  localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] MASK_OFS   = 32'h0000_0008;
  localparam logic [3:0]  BYTEENABLE = 4'hF;

endpackage

// File: rtl/pio_poll_timer.sv
// Load/count-to-zero interval counter; expired is high once PERIOD-1 decrements have elapsed.
module pio_poll_timer #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(PERIOD - 1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/key_pio_irq_master.sv
// Avalon-MM initiator servicing a key PIO: irq-triggered read, hold polling, mask restore.
// Optional readdatavalid watchdog is built when KEY_PIO_MASTER_TIMEOUT_EN is defined.
module key_pio_irq_master
  import key_pio_pkg::*;
#(
  parameter int               WIDTH          = 4,
  parameter logic [31:0]      BASE_ADDR      = 32'h0000_0000,
  parameter logic [WIDTH-1:0] MASK_INIT      = 4'hF,
  parameter int               POLL_CYCLES    = 50000,
  parameter int               TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_in,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic [3:0]       avm_byteenable,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  input  logic             avm_readdatavalid,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_level,
  output logic [WIDTH-1:0] evt_rise,
  output logic             overflow,
  output logic             timeout_err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mask_reg, mask_next, held_reg;
  logic [WIDTH-1:0] rd_data, rise, held_new, mask_new;
  logic             rdv_fire, rd_timeout, evt_load;
  logic             poll_entry, poll_expired;
  logic             avm_read_next, avm_write_next;
  logic [31:0]      avm_address_next, avm_writedata_next;
  logic             unused_bits;

  assign rd_data        = avm_readdata[WIDTH-1:0];
  assign rdv_fire       = (state_reg == S_RDV) && avm_readdatavalid;
  assign rise           = rd_data & ~held_reg & MASK_INIT;
  assign held_new       = rd_data & MASK_INIT;
  assign mask_new       = MASK_INIT & ~rd_data;
  assign mask_next      = rdv_fire ? mask_new : mask_reg;
  assign evt_load       = rdv_fire && (rise != '0);
  assign poll_entry     = (state_next == S_POLL) && (state_reg != S_POLL);
  assign avm_byteenable = BYTEENABLE;
  assign unused_bits    = ^{avm_readdata[31:WIDTH], TIMEOUT_CYCLES[0]};

  pio_poll_timer #(.PERIOD(POLL_CYCLES)) u_poll_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (poll_entry),
    .expired (poll_expired)
  );

`ifdef KEY_PIO_MASTER_TIMEOUT_EN
  logic rdv_entry, wd_expired;

  assign rdv_entry  = (state_next == S_RDV) && (state_reg != S_RDV);
  assign rd_timeout = (state_reg == S_RDV) && !avm_readdatavalid && wd_expired;

  pio_poll_timer #(.PERIOD(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (rdv_entry),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (rd_timeout) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign rd_timeout  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WMASK;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshakes qualify on our own registered request so the reset cycle never counts as accepted.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_WMASK: if (avm_write && !avm_waitrequest) state_next = (held_reg != '0) ? S_POLL : S_IDLE;
      S_IDLE:  if (irq_in) state_next = S_RD;
      S_POLL:  if (poll_expired) state_next = S_RD;
      S_RD:    if (avm_read && !avm_waitrequest) state_next = S_RDV;
      S_RDV: begin
        if (rdv_fire) begin
          if (mask_new != mask_reg)  state_next = S_WMASK;
          else if (held_new != '0)   state_next = S_POLL;
          else                       state_next = S_IDLE;
        end else if (rd_timeout) begin
          state_next = S_POLL;
        end
      end
      default: state_next = S_WMASK;
    endcase
  end

  always_comb begin
    avm_read_next      = 1'b0;
    avm_write_next     = 1'b0;
    avm_address_next   = '0;
    avm_writedata_next = '0;
    unique case (state_next)
      S_WMASK: begin
        avm_write_next     = 1'b1;
        avm_address_next   = BASE_ADDR + MASK_OFS;
        avm_writedata_next = 32'(mask_next);
      end
      S_RD: begin
        avm_read_next    = 1'b1;
        avm_address_next = BASE_ADDR + DATA_OFS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      avm_read      <= avm_read_next;
      avm_write     <= avm_write_next;
      avm_address   <= avm_address_next;
      avm_writedata <= avm_writedata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg <= MASK_INIT;
      held_reg <= '0;
    end else if (rdv_fire) begin
      mask_reg <= mask_new;
      held_reg <= held_new;
    end
  end

  // A load into a still-pending slot merges rise bits and flags the loss of the older level snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_level <= '0;
      evt_rise  <= '0;
      overflow  <= 1'b0;
    end else if (evt_load) begin
      evt_valid <= 1'b1;
      evt_level <= rd_data;
      if (evt_valid && !evt_ready) begin
        evt_rise <= evt_rise | rise;
        overflow <= 1'b1;
      end else begin
        evt_rise <= rise;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_pio_irq_master.sv
// Bench for key_pio_irq_master: behavioural PIO responder plus key-set reference model.
module tb_key_pio_irq_master;

  localparam int          WIDTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [3:0]  MINIT = 4'hF;
  localparam int          POLL  = 16;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset, irq_in;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;
  logic        evt_valid, evt_ready, overflow, timeout_err;
  logic [3:0]  evt_level, evt_rise;

  // Responder / environment state
  logic [3:0]  keys = 4'h0;
  logic [3:0]  pio_mask = 4'h0;
  bit          irq_force = 1'b0;
  int          stall_cfg = 0;
  int          stall_left = 0;
  int          cyc = 0;
  bit          in_req = 1'b0, rd_pend = 1'b0;
  logic [31:0] rd_word = '0;
  bit          st_rd, st_wr;
  logic [31:0] st_addr, st_wd;
  txn_t        log_q[$];
  bit          stab_q[$];

  // Reference model of what the master should have done with the key reads
  logic [3:0]  m_held = 4'h0, m_mask = MINIT, m_rise = 4'h0, m_level = 4'h0;
  bit          m_valid = 1'b0, m_ovf = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  key_pio_irq_master #(
    .WIDTH          (WIDTH),
    .BASE_ADDR      (BASE),
    .MASK_INIT      (MINIT),
    .POLL_CYCLES    (POLL),
    .TIMEOUT_CYCLES (256)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .irq_in            (irq_in),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .evt_valid         (evt_valid),
    .evt_ready         (evt_ready),
    .evt_level         (evt_level),
    .evt_rise          (evt_rise),
    .overflow          (overflow),
    .timeout_err       (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Key-level rules: new presses raise events, held keys get masked, releases unmask.
  task automatic model_read(input logic [3:0] d, output bit wr, output logic [3:0] nm);
    logic [3:0] r;
    r      = d & ~m_held & MINIT;
    m_held = d & MINIT;
    nm     = MINIT & ~d;
    wr     = (nm != m_mask);
    m_mask = nm;
    if (r != 4'h0) begin
      if (m_valid) begin
        m_rise = m_rise | r;
        m_ovf  = 1'b1;
      end else begin
        m_rise = r;
      end
      m_level = d;
      m_valid = 1'b1;
    end
  endtask

  task automatic get_txn(output txn_t t, output bit ok);
    int n = 0;
    while (log_q.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (log_q.size() != 0);
    if (ok) t = log_q.pop_front();
    chk("txn_wait", 32'(ok), 32'd1);
  endtask

  task automatic check_evt(input string tag);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 32'(m_valid));
    chk({tag, "_evt_rise"},  32'(evt_rise),  32'(m_rise));
    chk({tag, "_evt_level"}, 32'(evt_level), 32'(m_level));
    chk({tag, "_overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic service_read(input string tag, output logic [3:0] d, output int rcyc);
    txn_t       t;
    bit         ok, wr;
    logic [3:0] nm;
    d    = 4'h0;
    rcyc = 0;
    get_txn(t, ok);
    if (ok) begin
      chk({tag, "_rd_kind"}, 32'(t.is_wr), 32'd0);
      chk({tag, "_rd_addr"}, t.addr, BASE);
      d    = t.data[3:0];
      rcyc = t.cyc;
      model_read(d, wr, nm);
      if (wr) begin
        get_txn(t, ok);
        if (ok) begin
          chk({tag, "_wr_kind"}, 32'(t.is_wr), 32'd1);
          chk({tag, "_wr_addr"}, t.addr, BASE + 32'h8);
          chk({tag, "_wr_data"}, t.data, {28'h0, nm});
        end
      end else begin
        repeat (2) @(negedge clk);
      end
      check_evt(tag);
    end
  endtask

  task automatic service_until(input string tag);
    logic [3:0] d;
    int         c;
    d = ~keys;
    for (int k = 0; k < 4 && d != keys; k++) service_read(tag, d, c);
    chk({tag, "_converge"}, 32'(d), 32'(keys));
  endtask

  task automatic ack_event(input string tag);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    m_valid   = 1'b0;
    @(negedge clk);
    chk(tag, 32'(evt_valid), 32'd0);
  endtask

  initial begin : responder
    txn_t        t;
    logic [31:0] noise;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    irq_in            = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      noise             = $urandom();
      avm_readdatavalid = 1'b0;
      avm_readdata      = noise;
      if (reset) begin
        in_req          = 1'b0;
        rd_pend         = 1'b0;
        pio_mask        = 4'h0;
        avm_waitrequest = 1'b0;
      end else begin
        if (rd_pend) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rd_word;
          rd_pend           = 1'b0;
        end
        if (avm_read || avm_write) begin
          if (!in_req) begin
            in_req     = 1'b1;
            stall_left = stall_cfg;
            st_rd      = avm_read;
            st_wr      = avm_write;
            st_addr    = avm_address;
            st_wd      = avm_writedata;
          end else begin
            stab_q.push_back(avm_read == st_rd && avm_write == st_wr &&
                             avm_address == st_addr && avm_writedata == st_wd);
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
            in_req  = 1'b0;
            t.is_wr = avm_write;
            t.addr  = avm_address;
            t.cyc   = cyc;
            t.data  = avm_write ? avm_writedata : {noise[31:4], keys};
            if (avm_read) begin
              rd_pend = 1'b1;
              rd_word = t.data;
            end
            if (avm_write && avm_address == BASE + 32'h8) pio_mask = avm_writedata[3:0];
            log_q.push_back(t);
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
      end
      irq_in = (|(keys & pio_mask)) | irq_force;
    end
  end

  initial begin : main
    txn_t       t;
    bit         ok;
    logic [3:0] d;
    int         c1, c2, n, bad;

    reset     = 1'b1;
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read",       32'(avm_read),       32'd0);
    chk("rst_write",      32'(avm_write),      32'd0);
    chk("rst_address",    avm_address,         32'd0);
    chk("rst_writedata",  avm_writedata,       32'd0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'hF);
    check_evt("rst");
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Initial mask write, then silence while no key is pressed
    get_txn(t, ok);
    if (ok) begin
      chk("init_wr_kind", 32'(t.is_wr), 32'd1);
      chk("init_wr_addr", t.addr, BASE + 32'h8);
      chk("init_wr_data", t.data, 32'h0000_000F);
    end
    repeat (3 * POLL) @(negedge clk);
    chk("idle_no_txn", 32'(log_q.size()), 32'd0);

    // Press key 1: event, mask 0xD, then polling at a fixed interval
    keys = 4'h2;
    service_until("press2");
    chk("press2_rise_const", 32'(evt_rise), 32'h2);
    service_read("poll_a", d, c1);
    service_read("poll_b", d, c2);
    chk("poll_spacing", 32'(c2 - c1), 32'(POLL + 2));

    // Release: mask restored, idle, old event still pending until accepted
    keys = 4'h0;
    service_until("release2");
    repeat (3 * POLL) @(negedge clk);
    chk("release_idle_no_txn", 32'(log_q.size()), 32'd0);
    check_evt("release2_hold");
    ack_event("ack1");

    // Second press while first still held and unaccepted: merge + overflow
    keys = 4'h1;
    service_until("press1");
    keys = 4'h5;
    service_until("press4");
    chk("merge_rise",  32'(evt_rise),  32'h5);
    chk("merge_level", 32'(evt_level), 32'h5);
    chk("merge_ovf",   32'(overflow),  32'd1);
    ack_event("ack2");
    keys = 4'h0;
    service_until("release5");

    // Spurious irq with a stalled read: no event, no write, request held steady
    stab_q.delete();
    stall_cfg = 5;
    irq_force = 1'b1;
    n = 0;
    while (!avm_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    irq_force = 1'b0;
    service_read("spurious", d, c1);
    stall_cfg = 0;
    chk("stall_samples", 32'(stab_q.size()), 32'd5);
    bad = 0;
    foreach (stab_q[i]) if (!stab_q[i]) bad++;
    chk("stall_stable", 32'(bad), 32'd0);
    repeat (3 * POLL) @(negedge clk);
    chk("spurious_no_txn", 32'(log_q.size()), 32'd0);
    check_evt("spurious_after");

    // Randomised key patterns with random wait states and accepts
    stab_q.delete();
    for (int it = 0; it < 12; it++) begin
      if (m_valid && $urandom_range(0, 1) == 1) ack_event("rnd_ack");
      stall_cfg = $urandom_range(0, 3);
      keys      = 4'($urandom_range(0, 15));
      if (m_held == 4'h0 && keys == 4'h0) begin
        repeat (2 * POLL) @(negedge clk);
        chk("rnd_quiet", 32'(log_q.size()), 32'd0);
      end else begin
        service_until("rnd");
      end
    end
    stall_cfg = 0;
    keys      = 4'h0;
    if (m_held != 4'h0) service_until("rnd_release");
    repeat (3 * POLL) @(negedge clk);
    chk("final_no_txn", 32'(log_q.size()), 32'd0);
    bad = 0;
    foreach (stab_q[i]) if (!stab_q[i]) bad++;
    chk("rnd_stall_stable", 32'(bad), 32'd0);
    check_evt("final");
    chk("final_timeout_err", 32'(timeout_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
